// File: rtl/ripple_carry_counter_pkg.sv
// Shared constants for the ripple-chain up-counter.
package ripple_carry_counter_pkg;
    localparam int COUNTER_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/ripple_carry_counter_if.sv
// Count output bundle; master drives the count, slave observes it.
interface ripple_carry_counter_if
    import ripple_carry_counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT
);
    logic [WIDTH-1:0] q;

    modport master (output q);
    modport slave  (input  q);
endinterface

// File: rtl/ripple_carry_counter_d_ff.sv
// Negative-edge D flip-flop with asynchronous active-low clear.
module d_ff (
    input  logic d,
    input  logic clk,
    input  logic reset,
    output logic q
);
    logic r_q;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;
endmodule

// File: rtl/ripple_carry_counter_t_ff.sv
// Toggle flip-flop: inverts on each falling clk edge, cleared while reset is low.
module t_ff (
    output logic q,
    input  logic clk,
    input  logic reset
);
    logic w_d;

    assign w_d = ~q;

    d_ff u_dff (
        .d     (w_d),
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );
endmodule

// File: rtl/ripple_carry_counter.sv
// Asynchronous ripple up-counter: stage 0 toggles on clk fall, stage i on stage i-1 fall.
// Outputs skew by one clock-to-q per stage; sample only after the chain settles.
module ripple_carry_counter
    import ripple_carry_counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
    ripple_carry_counter_if.master q,
    input  logic                   clk,
    input  logic                   reset
);
    logic [WIDTH-1:0] w_q;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_stage
            if (i == 0) begin : g_first
                t_ff u_tff (
                    .q     (w_q[0]),
                    .clk   (clk),
                    .reset (reset)
                );
            end else begin : g_rest
                // A 1->0 transition of the lower bit is exactly its carry out.
                t_ff u_tff (
                    .q     (w_q[i]),
                    .clk   (w_q[i-1]),
                    .reset (reset)
                );
            end
        end
    endgenerate

    assign q.q = w_q;
endmodule

// File: tb/tb_ripple_carry_counter.sv
// Bench for ripple_carry_counter at widths 1, 4 and 8 sharing one clock and reset.
module tb_ripple_carry_counter;
    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;
    int cnt    = 0;

    ripple_carry_counter_if #(.WIDTH(1)) if1 ();
    ripple_carry_counter_if #(.WIDTH(4)) if4 ();
    ripple_carry_counter_if #(.WIDTH(8)) if8 ();

    ripple_carry_counter #(.WIDTH(1)) dut1 (.q(if1), .clk(clk), .reset(reset));
    ripple_carry_counter #(.WIDTH(4)) dut4 (.q(if4), .clk(clk), .reset(reset));
    ripple_carry_counter #(.WIDTH(8)) dut8 (.q(if8), .clk(clk), .reset(reset));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: n effective falling edges since reset, reduced modulo 2^WIDTH per instance.
    function automatic logic [12:0] exp_cat(input int n);
        logic [7:0] e8;
        logic [3:0] e4;
        logic       e1;
        e8 = 8'(n % 256);
        e4 = 4'(n % 16);
        e1 = 1'(n % 2);
        return {e8, e4, e1};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if ({if8.q, if4.q, if1.q} !== exp_cat(0)) begin
            errors++;
            $display("FAIL reset_t1 got=%h want=%h", {if8.q, if4.q, if1.q}, exp_cat(0));
        end
        #10;
        checks++;
        if ({if8.q, if4.q, if1.q} !== exp_cat(0)) begin
            errors++;
            $display("FAIL reset_after_fall got=%h want=%h", {if8.q, if4.q, if1.q}, exp_cat(0));
        end
        #4;
        reset = 1'b1;
        cnt = 0;
    endtask

    task automatic test_count_wrap();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            cnt++;
            #1;
            checks++;
            if ({if8.q, if4.q, if1.q} !== exp_cat(cnt)) begin
                errors++;
                $display("FAIL count_k%0d t=%0t got=%h want=%h", k, $time, {if8.q, if4.q, if1.q}, exp_cat(cnt));
            end
            @(posedge clk);
            #1;
            checks++;
            if ({if8.q, if4.q, if1.q} !== exp_cat(cnt)) begin
                errors++;
                $display("FAIL rise_no_effect_k%0d got=%h want=%h", k, {if8.q, if4.q, if1.q}, exp_cat(cnt));
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (2) begin
            @(negedge clk);
            cnt++;
        end
        #5;
        reset = 1'b0;
        cnt = 0;
        #1;
        checks++;
        if ({if8.q, if4.q, if1.q} !== exp_cat(0)) begin
            errors++;
            $display("FAIL midcount_clear t=%0t got=%h want=%h", $time, {if8.q, if4.q, if1.q}, exp_cat(0));
        end
        #9;
        reset = 1'b1;
        #1;
        checks++;
        if ({if8.q, if4.q, if1.q} !== exp_cat(0)) begin
            errors++;
            $display("FAIL after_release got=%h want=%h", {if8.q, if4.q, if1.q}, exp_cat(0));
        end
        @(negedge clk);
        cnt++;
        #1;
        checks++;
        if ({if8.q, if4.q, if1.q} !== exp_cat(cnt)) begin
            errors++;
            $display("FAIL first_after_release got=%h want=%h", {if8.q, if4.q, if1.q}, exp_cat(cnt));
        end
    endtask

    task automatic test_reset_hold();
        @(posedge clk);
        #2;
        reset = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            checks++;
            if ({if8.q, if4.q, if1.q} !== exp_cat(0)) begin
                errors++;
                $display("FAIL hold_fall got=%h want=%h", {if8.q, if4.q, if1.q}, exp_cat(0));
            end
            @(posedge clk);
            #1;
            checks++;
            if ({if8.q, if4.q, if1.q} !== exp_cat(0)) begin
                errors++;
                $display("FAIL hold_rise got=%h want=%h", {if8.q, if4.q, if1.q}, exp_cat(0));
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_width8_wrap();
        @(posedge clk);
        #2;
        reset = 1'b0;
        cnt = 0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            cnt++;
            #1;
            checks++;
            if ({if8.q, if4.q, if1.q} !== exp_cat(cnt)) begin
                errors++;
                $display("FAIL wide_k%0d got=%h want=%h", k, {if8.q, if4.q, if1.q}, exp_cat(cnt));
            end
        end
        if (if8.q !== 8'd0) begin
            errors++;
            $display("FAIL wide_wrap got=%0d want=0", if8.q);
        end
        checks++;
    endtask

    task automatic test_random();
        @(posedge clk);
        #1;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                #($urandom_range(1, 2));
                reset = 1'b0;
                cnt = 0;
                #1;
                checks++;
                if ({if8.q, if4.q, if1.q} !== exp_cat(0)) begin
                    errors++;
                    $display("FAIL rand_clear it=%0d got=%h want=%h", it, {if8.q, if4.q, if1.q}, exp_cat(0));
                end
                repeat (1 + $urandom_range(0, 3)) @(negedge clk);
                #1;
                checks++;
                if ({if8.q, if4.q, if1.q} !== exp_cat(0)) begin
                    errors++;
                    $display("FAIL rand_hold it=%0d got=%h want=%h", it, {if8.q, if4.q, if1.q}, exp_cat(0));
                end
                #($urandom_range(0, 2));
                reset = 1'b1;
            end
            @(negedge clk);
            cnt++;
            #1;
            checks++;
            if ({if8.q, if4.q, if1.q} !== exp_cat(cnt)) begin
                errors++;
                $display("FAIL rand_fall it=%0d got=%h want=%h", it, {if8.q, if4.q, if1.q}, exp_cat(cnt));
            end
            @(posedge clk);
            #1;
            checks++;
            if ({if8.q, if4.q, if1.q} !== exp_cat(cnt)) begin
                errors++;
                $display("FAIL rand_rise it=%0d got=%h want=%h", it, {if8.q, if4.q, if1.q}, exp_cat(cnt));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count_wrap();
        test_async_reset();
        test_reset_hold();
        test_width8_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
